// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// FSM encodings live here together with the default latency and starvation limits.
package dmem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_AUX_BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_MEM_LATENCY = 1;
    localparam int unsigned DEF_STARVE_MAX  = 8;
    localparam int unsigned LAT_W           = 4;
    localparam int unsigned STARVE_W        = 8;
    localparam int unsigned MASK_W          = 4;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating wait counter: counts up on inc_i, clears on clr_i, flags saturation at MAX.
module arb_starve_counter #(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    logic [W-1:0] cnt_q;

    assign sat_o = (cnt_q == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !sat_o) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter sharing the data-memory port with one aux master.
// Optional performance counters are enabled with `define DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int unsigned STARVE_MAX  = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              cpu_memwrite_i,
    input  logic              cpu_memread_i,
    input  logic [MASK_W-1:0] cpu_sign_mask_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              aux_req_i,
    input  logic              aux_we_i,
    input  logic [ADDR_W-1:0] aux_addr_i,
    input  logic [DATA_W-1:0] aux_wdata_i,
    input  logic [MASK_W-1:0] aux_sign_mask_i,
    output logic              aux_gnt_o,
    output logic              aux_rvalid_o,
    output logic [DATA_W-1:0] aux_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_memwrite_o,
    output logic              mem_memread_o,
    output logic [MASK_W-1:0] mem_sign_mask_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [15:0]       perf_force_cnt_o
`endif
);

    arb_state_e        state_q;
    logic [LAT_W-1:0]  lat_q;
    logic              aux_we_q;
    logic [ADDR_W-1:0] aux_addr_q;
    logic [DATA_W-1:0] aux_wdata_q;
    logic [MASK_W-1:0] aux_mask_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic cpu_access;
    logic idle;
    logic busy;
    logic grant;
    logic starve_sat;

    assign cpu_access = cpu_memread_i | cpu_memwrite_i;
    assign idle       = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_AUX_BUSY) & ~rst;
    // The CPU keeps the port unless the aux has waited the full starvation budget.
    assign grant      = idle & ~rst & aux_req_i & (~cpu_access | starve_sat);

    assign aux_gnt_o    = grant;
    assign cpu_stall_o  = busy;
    assign aux_rvalid_o = rvalid_q;
    assign aux_rdata_o  = rdata_q;

    arb_starve_counter #(
        .MAX (STARVE_MAX),
        .W   (STARVE_W)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc_i (idle & aux_req_i & ~grant),
        .clr_i (~aux_req_i | grant),
        .sat_o (starve_sat)
    );

    // Memory port mux: CPU pass-through by default, registered aux fields while busy.
    always_comb begin
        mem_addr_o      = cpu_addr_i;
        mem_wdata_o     = cpu_wdata_i;
        mem_memwrite_o  = cpu_memwrite_i & ~rst;
        mem_memread_o   = cpu_memread_i & ~rst;
        mem_sign_mask_o = cpu_sign_mask_i;
        cpu_rdata_o     = mem_rdata_i;
        if (busy) begin
            mem_addr_o      = aux_addr_q;
            mem_wdata_o     = aux_wdata_q;
            mem_memwrite_o  = aux_we_q;
            mem_memread_o   = ~aux_we_q;
            mem_sign_mask_o = aux_mask_q;
            cpu_rdata_o     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lat_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        state_q <= ST_AUX_BUSY;
                        lat_q   <= LAT_W'(MEM_LATENCY - 1);
                    end
                end
                ST_AUX_BUSY: begin
                    if (lat_q == '0) begin
                        state_q  <= ST_IDLE;
                        rvalid_q <= 1'b1;
                        if (!aux_we_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Aux command capture; only meaningful while busy, so no reset needed.
    always_ff @(posedge clk) begin
        if (grant) begin
            aux_we_q    <= aux_we_i;
            aux_addr_q  <= aux_addr_i;
            aux_wdata_q <= aux_wdata_i;
            aux_mask_q  <= aux_sign_mask_i;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] force_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            force_cnt_q <= '0;
        end else begin
            if (cpu_stall_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (grant && cpu_access) begin
                force_cnt_q <= force_cnt_q + 16'd1;
            end
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_force_cnt_o = force_cnt_q;
`endif

endmodule
